pipe_hazard_unit: RTL and testbench

- Parametrised hazard-detection and forwarding controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Keeps its own shadow scoreboard of the EX, MEM and WB slots: valid, destination id, write enable and is-load.
- Drives registered forwarding selects into the EX-stage operand muxes, plus stall, bubble and flush controls for the PC and the IF/ID and ID/EX pipeline registers.
- Replaces the current hazard-free operation, in which back-to-back dependent instructions read stale register-file data.

---
 rtl/pipe_hazard_unit.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand-forwarding controller for a 5-stage pipeline.
// A shadow scoreboard of EX/MEM/WB drives forward selects, load-use stalls and branch flushes.
module pipe_hazard_unit #(
  parameter int ID_LENGTH          = 3,
  parameter int ZERO_REG_HARDWIRED = 0,
  parameter int BRANCH_SHADOW      = 1,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [ID_LENGTH-1:0] id_src1,
  input  logic                 id_src1_used,
  input  logic [ID_LENGTH-1:0] id_src2,
  input  logic                 id_src2_used,
  input  logic [ID_LENGTH-1:0] id_dst,
  input  logic                 id_wr_en,
  input  logic                 id_is_load,
  input  logic                 ex_branch_taken,
  input  logic                 ext_stall,
  output logic [1:0]           fwd_sel1,
  output logic [1:0]           fwd_sel2,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [ID_LENGTH-1:0] dst;
    logic                 wr_en;
  } slot_t;

  typedef enum logic [1:0] {RUN, STALL_LU, FLUSH} state_t;

  // Only the EX occupant's load flag matters: a load is hazardous only one slot ahead.
  slot_t      ex_slot, mem_slot, wb_slot;
  logic       ex_is_load;
  state_t     state, state_nxt;
  logic [1:0] kill, kill_nxt;
  logic [1:0] sel1_c, sel2_c;
  logic       hazard, lu_stall, flush_evt;

  function automatic logic src_match(input logic [ID_LENGTH-1:0] src, input logic used,
                                     input slot_t s);
    return used && s.valid && s.wr_en && (s.dst == src) &&
           !((ZERO_REG_HARDWIRED != 0) && (src == '0));
  endfunction

  function automatic logic [1:0] pick_src(input logic [ID_LENGTH-1:0] src, input logic used,
                                          input slot_t ex_s, input slot_t mem_s,
                                          input slot_t wb_s);
    if (src_match(src, used, ex_s))       return 2'd1;
    else if (src_match(src, used, mem_s)) return 2'd2;
    else if (src_match(src, used, wb_s))  return 2'd3;
    else                                  return 2'd0;
  endfunction

  assign sel1_c = pick_src(id_src1, id_src1_used, ex_slot, mem_slot, wb_slot);
  assign sel2_c = pick_src(id_src2, id_src2_used, ex_slot, mem_slot, wb_slot);
  assign hazard = ex_is_load && (src_match(id_src1, id_src1_used, ex_slot) ||
                                 src_match(id_src2, id_src2_used, ex_slot));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    lu_stall     = 1'b0;
    flush_evt    = 1'b0;
    state_nxt    = state;
    kill_nxt     = kill;
    // Controls are gated by reset too, so an asserted rst silences them without a clock.
    if (!rst) begin
      state_nxt = RUN;
    end else if (ext_stall) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_evt    = 1'b1;
      state_nxt    = (BRANCH_SHADOW > 0) ? FLUSH : RUN;
      kill_nxt     = 2'(BRANCH_SHADOW);
    end else if (state == FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      kill_nxt     = kill - 2'd1;
      state_nxt    = (kill <= 2'd1) ? RUN : FLUSH;
    end else if (hazard && state != STALL_LU) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
      lu_stall     = 1'b1;
      state_nxt    = STALL_LU;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_slot    <= '0;
      mem_slot   <= '0;
      wb_slot    <= '0;
      ex_is_load <= 1'b0;
      state      <= RUN;
      kill       <= '0;
      fwd_sel1   <= '0;
      fwd_sel2   <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (!ext_stall) begin
      // NOTE: non-blocking assignments let the slots shift together without ordering races.
      wb_slot    <= mem_slot;
      mem_slot   <= ex_slot;
      ex_slot    <= '{valid: id_valid & ~id_ex_bubble, dst: id_dst, wr_en: id_wr_en};
      ex_is_load <= id_is_load;
      state      <= state_nxt;
      kill       <= kill_nxt;
      fwd_sel1   <= id_ex_bubble ? 2'd0 : sel1_c;
      fwd_sel2   <= id_ex_bubble ? 2'd0 : sel2_c;
      if (lu_stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus randomized traffic
// compared against an instruction-history reference model.
module tb_pipe_hazard_unit;

  localparam int ZERO   = 1;
  localparam int SHADOW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_src1_used, id_src2_used, id_wr_en, id_is_load;
  logic [2:0]  id_src1, id_src2, id_dst;
  logic        ex_branch_taken, ext_stall;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  ctl;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_hold, if_id_hold, if_id_flush, id_ex_bubble};

  pipe_hazard_unit #(
    .ID_LENGTH(3), .ZERO_REG_HARDWIRED(ZERO), .BRANCH_SHADOW(SHADOW), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: the last three instructions that entered EX, youngest first.
  typedef struct {bit v; bit [2:0] dst; bit we; bit ld;} instr_t;
  instr_t     hist[3];
  int         kill_left;
  bit         just_stalled;
  int         m_stall, m_flush;
  bit [1:0]   m_sel1, m_sel2;

  function automatic bit writes(int k, bit [2:0] src, bit used);
    return used && hist[k].v && hist[k].we && hist[k].dst == src && (ZERO == 0 || src != 0);
  endfunction

  function automatic bit [1:0] youngest(bit [2:0] src, bit used);
    for (int k = 0; k < 3; k++)
      if (writes(k, src, used)) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic bit [3:0] model_ctl();
    bit lu;
    lu = !just_stalled && hist[0].ld &&
         (writes(0, id_src1, id_src1_used) || writes(0, id_src2, id_src2_used));
    if (ext_stall)                          return 4'b1100;
    if (ex_branch_taken || kill_left > 0)   return 4'b0011;
    if (lu)                                 return 4'b1101;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{v: 0, dst: 0, we: 0, ld: 0};
    kill_left = 0; just_stalled = 0; m_stall = 0; m_flush = 0; m_sel1 = 0; m_sel2 = 0;
  endtask

  task automatic model_step();
    bit [3:0] c;
    if (ext_stall) return;
    c = model_ctl();
    m_sel1 = c[0] ? 2'd0 : youngest(id_src1, id_src1_used);
    m_sel2 = c[0] ? 2'd0 : youngest(id_src2, id_src2_used);
    if (ex_branch_taken) begin
      m_flush++;
      kill_left = SHADOW;
    end else if (kill_left > 0) begin
      kill_left--;
    end
    just_stalled = (c == 4'b1101);
    if (just_stalled) m_stall++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{v: id_valid & ~c[0], dst: id_dst, we: id_wr_en, ld: id_is_load};
  endtask

  task automatic drive(input bit v, input bit [2:0] s1, input bit u1, input bit [2:0] s2,
                       input bit u2, input bit [2:0] d, input bit we, input bit ld,
                       input bit br, input bit xs);
    id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    id_dst = d; id_wr_en = we; id_is_load = ld; ex_branch_taken = br; ext_stall = xs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({fwd_sel1, fwd_sel2, ctl, stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_state got sel=%0d/%0d ctl=%b stall=%0d flush=%0d want all 0",
               fwd_sel1, fwd_sel2, ctl, stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_alu_chain();
    do_reset();
    drive(1, 6, 0, 7, 0, 1, 1, 0, 0, 0);  // ADD r1
    tick();
    drive(1, 1, 1, 7, 0, 2, 1, 0, 0, 0);  // ADD r2,r1
    @(negedge clk);
    total++;
    if (ctl !== 4'b0000) $display("FAIL chain_no_stall got %b want 0000", ctl); else passed++;
    tick();
    total++;
    if (fwd_sel1 !== 2'd1) $display("FAIL chain_sel_ex got %0d want 1", fwd_sel1); else passed++;
    drive(1, 1, 1, 7, 0, 3, 1, 0, 0, 0);  // ADD r3,r1
    tick();
    total++;
    if (fwd_sel1 !== 2'd2) $display("FAIL chain_sel_mem got %0d want 2", fwd_sel1); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if (stall_cnt !== 16'd0) $display("FAIL chain_stall_cnt got %0d want 0", stall_cnt); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);  // LOAD r4
    tick();
    drive(1, 4, 1, 4, 1, 5, 1, 0, 0, 0);  // ADD r5,r4,r4
    @(negedge clk);
    total++;
    if (ctl !== 4'b1101) $display("FAIL lu_stall_ctl got %b want 1101", ctl); else passed++;
    tick();
    @(negedge clk);
    total++;
    if (ctl !== 4'b0000) $display("FAIL lu_single_cycle got %b want 0000", ctl); else passed++;
    tick();
    total++;
    if ({fwd_sel1, fwd_sel2} !== 4'b1010)
      $display("FAIL lu_fwd got %0d/%0d want 2/2", fwd_sel1, fwd_sel2);
    else passed++;
    total++;
    if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); else passed++;
  endtask

  task automatic test_branch_shadow();
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== ((c < 3) ? 4'b0011 : 4'b0000))
        $display("FAIL branch_cycle%0d got %b want %b", c, ctl, (c < 3) ? 4'b0011 : 4'b0000);
      else passed++;
      tick();
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    end
    total++;
    if (flush_cnt !== 16'd1) $display("FAIL branch_flush_cnt got %0d want 1", flush_cnt); else passed++;
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 1, 0);
    @(negedge clk);
    total++;
    if (ctl !== 4'b0011) $display("FAIL br_lu_ctl got %b want 0011", ctl); else passed++;
    tick();
    total++;
    if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1})
      $display("FAIL br_lu_counts got stall=%0d flush=%0d want 0/1", stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_ext_stall();
    do_reset();
    drive(1, 6, 0, 7, 0, 1, 1, 0, 0, 0);
    tick();
    drive(1, 1, 1, 7, 0, 2, 1, 0, 0, 0);
    tick();
    drive(1, 1, 1, 7, 0, 3, 1, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (ctl !== 4'b1100) $display("FAIL xs_ctl%0d got %b want 1100", c, ctl); else passed++;
      tick();
      total++;
      if ({fwd_sel1, stall_cnt, flush_cnt} !== {2'd1, 16'd0, 16'd0})
        $display("FAIL xs_frozen%0d got sel=%0d stall=%0d flush=%0d want 1/0/0",
                 c, fwd_sel1, stall_cnt, flush_cnt);
      else passed++;
    end
    ext_stall = 1'b0;
    tick();
    total++;
    if (fwd_sel1 !== 2'd2) $display("FAIL xs_resume got %0d want 2", fwd_sel1); else passed++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);  // load writing r0
    tick();
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0);  // read r0
    @(negedge clk);
    total++;
    if (ctl !== 4'b0000) $display("FAIL zero_no_stall got %b want 0000", ctl); else passed++;
    tick();
    total++;
    if ({fwd_sel1, fwd_sel2, stall_cnt} !== '0)
      $display("FAIL zero_fwd got sel=%0d/%0d stall=%0d want 0", fwd_sel1, fwd_sel2, stall_cnt);
    else passed++;
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    total++;
    if (ctl !== 4'b0011) $display("FAIL rstfl_pre got %b want 0011", ctl); else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({fwd_sel1, fwd_sel2, ctl, stall_cnt, flush_cnt} !== '0)
      $display("FAIL rstfl_async got ctl=%b flush=%0d want 0", ctl, flush_cnt);
    else passed++;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ctl !== 4'b0000) $display("FAIL rstfl_run got %b want 0000", ctl); else passed++;
  endtask

  task automatic test_random();
    bit [3:0] exp_ctl;
    int       errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            3'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
      if (!id_valid) begin
        id_src1_used = 1'b0;
        id_src2_used = 1'b0;
      end
      exp_ctl = model_ctl();
      @(negedge clk);
      total++;
      if (ctl !== exp_ctl) begin
        if (errs++ < 10) $display("FAIL rand_ctl@%0d got %b want %b", i, ctl, exp_ctl);
      end else passed++;
      model_step();
      tick();
      total++;
      if ({fwd_sel1, fwd_sel2, stall_cnt, flush_cnt} !==
          {m_sel1, m_sel2, 16'(m_stall), 16'(m_flush)}) begin
        if (errs++ < 10)
          $display("FAIL rand_regs@%0d got sel=%0d/%0d cnt=%0d/%0d want %0d/%0d %0d/%0d", i,
                   fwd_sel1, fwd_sel2, stall_cnt, flush_cnt, m_sel1, m_sel2, m_stall, m_flush);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_branch_shadow();
    test_branch_vs_load_use();
    test_ext_stall();
    test_zero_reg();
    test_reset_in_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
